// File: rtl/mult_seq_ctrl_if.sv
// Handshake bundle between a requester and the shift-and-add multiplier controller.
// The requester drives start/A/B; the controller returns ready/done/P.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] P;

  modport master (output start, A, B, input ready, done, P);
  modport slave  (input start, A, B, output ready, done, P);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one adder, two shifters, a bit counter.
// Optional MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_L,
  mult_seq_ctrl_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand, mcand_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [PW-1:0]    p, p_nxt;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplr, mplr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             last;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      count <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      acc   <= acc_nxt;
      mplr  <= mplr_nxt;
      count <= count_nxt;
      p     <= p_nxt;
    end
  end

  always_comb begin
    sum       = mplr[0] ? (acc + mcand) : acc;
`ifdef MULT_EARLY_TERM_EN
    last      = (count == LAST) || ((mplr >> 1) == '0);
`else
    last      = (count == LAST);
`endif
    state_nxt = state;
    mcand_nxt = mcand;
    acc_nxt   = acc;
    mplr_nxt  = mplr;
    count_nxt = count;
    p_nxt     = p;
    case (state)
      IDLE, DONE: begin
        // DONE accepts a new request too, giving back-to-back issue
        if (bus.start) begin
          state_nxt = CALC;
          mcand_nxt = {{WIDTH{1'b0}}, bus.A};
          mplr_nxt  = bus.B;
          acc_nxt   = '0;
          count_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        acc_nxt   = sum;
        mcand_nxt = mcand << 1;
        mplr_nxt  = mplr >> 1;
        count_nxt = count + 1'b1;
        if (last) begin
          state_nxt = DONE;
          p_nxt     = sum;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready = (state != CALC);
  assign bus.done  = (state == DONE);
  assign bus.P     = p;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: vector table plus back-to-back and reset-abort sequences.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_L;
  int   total;
  int   passed;

  mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    else
      passed++;
  endtask

  // Expected CALC cycles for multiplier b
  function automatic int exp_lat(input logic [7:0] b);
    int l;
    l = 1;
    for (int i = 0; i < 8; i++)
      if (b[i]) l = i + 1;
`ifndef MULT_EARLY_TERM_EN
    l = WIDTH;
`endif
    return l;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input string tag);
    int          cyc;
    bit          seen;
    bit          glitch;
    logic [15:0] p_old;
    p_old = bus.P;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    chk({tag, " ready_calc"}, 32'(bus.ready), 32'd0);
    cyc = 0;
    seen = 1'b0;
    glitch = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) seen = 1'b1;
      else if (bus.P !== p_old || bus.ready !== 1'b0) glitch = 1'b1;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat(b)));
    chk({tag, " calc_quiet"}, 32'(glitch), 32'd0);
    chk({tag, " P"}, 32'(bus.P), 32'(exp_p));
    chk({tag, " ready_done"}, 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, " P_hold"}, 32'(bus.P), 32'(exp_p));
  endtask

  initial begin
    int cyc;
    int first;
    int second;
    int stray;

    total  = 0;
    passed = 0;
    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{8'hFF,  8'h00,  16'h0000};
    vecs[3] = '{8'd100, 8'h03,  16'd300};
    vecs[4] = '{8'h00,  8'hFF,  16'h0000};
    vecs[5] = '{8'h01,  8'h80,  16'h0080};
    vecs[6] = '{8'h80,  8'h80,  16'h4000};
    vecs[7] = '{8'd12,  8'd13,  16'd156};
    vecs[8] = '{8'hAA,  8'h55,  16'h3872};

    rst_L     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2;
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset done",  32'(bus.done),  32'd0);
    chk("reset P",     32'(bus.P),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_L = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start held high; operands for the second op appear only in DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd7;
    bus.B = 8'd9;
    @(posedge clk);
    #1;
    cyc = 0;
    first = -1;
    second = -1;
    while (second < 0 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        if (first < 0) begin
          first = cyc;
          chk("b2b P1", 32'(bus.P), 32'd63);
          bus.A = 8'd12;
          bus.B = 8'd12;
        end else begin
          second = cyc;
          chk("b2b P2", 32'(bus.P), 32'd144);
          bus.start = 1'b0;
        end
      end else begin
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
      end
    end
    chk("b2b first_lat", 32'(first), 32'(exp_lat(8'd9)));
    chk("b2b interval", 32'(second - first), 32'(exp_lat(8'd12) + 1));
    @(posedge clk);
    #1;
    chk("b2b idle_ready", 32'(bus.ready), 32'd1);

    // asynchronous abort during CALC
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd10;
    bus.B = 8'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_L = 1'b0;
    #1;
    chk("abort ready", 32'(bus.ready), 32'd1);
    chk("abort done",  32'(bus.done),  32'd0);
    chk("abort P",     32'(bus.P),     32'd0);
    @(negedge clk);
    rst_L = 1'b1;
    stray = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) stray++;
    end
    chk("abort no_done", 32'(stray), 32'd0);
    chk("abort P_zero", 32'(bus.P), 32'd0);
    run_op(8'd2, 8'd3, 16'd6, "restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-and-add multiplier controller that time-shares one adder, a pair of shift registers and a bit-counter to form a 2·WIDTH-bit unsigned product of two WIDTH-bit operands. Offers a start/ready/done handshake to the surrounding logic, so one narrow adder replaces a full array multiplier. Sits between a requesting control block and the shared arithmetic datapath (adder, register, comparator primitives).

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2·WIDTH bits
- clk  input  1  rising-edge clock, single clock domain
- rst_L  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on clk rising edge only while ready=1
- A  input  WIDTH  multiplicand, captured on the accepted start edge
- B  input  WIDTH  multiplier, captured on the accepted start edge
- ready  output  1  controller can accept start this cycle
- done  output  1  one-cycle pulse: P holds a new valid product
- P  output  2·WIDTH  product register; holds until the next completion

## Operation
- States: IDLE, CALC, DONE. Reset (rst_L=0, any time, asynchronous) → IDLE; state, internal registers, count, P, done all forced to 0.
- ready = 1 in IDLE and DONE, 0 in CALC. done = 1 only in DONE.
- IDLE: start=1 → CALC; load mcand ← zero-extended A (2·WIDTH bits), mplr ← B, acc ← 0, count ← 0. start=0 → stay.
- CALC, each cycle: if mplr[0], acc ← acc + mcand (2·WIDTH-bit add, carry out discarded — it cannot occur for unsigned operands); mcand ← mcand << 1; mplr ← mplr >> 1; count ← count + 1.
- CALC exit: when the cycle being executed has count = WIDTH−1 → DONE; P ← final acc value (including this cycle's add) on that same edge.
- DONE: lasts one cycle. start=1 → CALC with new operands loaded exactly as from IDLE (back-to-back); else → IDLE.
- start in CALC: ignored; no effect on operands, count or state; no queueing.
- A, B may change freely after the accepting edge.
- P changes only on the edge entering DONE or on reset; it never shows intermediate sums.
- count width = $clog2(WIDTH) bits; compare against WIDTH−1, no wrap reliance.

## Timing
- Edge E0 accepts start. CALC occupies edges E1..E(WIDTH); DONE is the cycle after E(WIDTH); done high for exactly that one cycle.
- Start-to-done latency: WIDTH cycles (feature off). Issue interval back-to-back: WIDTH+1 cycles.
- P valid in the same cycle done is high, stable until the next done.
- ready is a registered-state decode (no combinational path from start).
- Reset mid-CALC: asynchronous abort, no done pulse, P = 0; first accepted start after rst_L rises restarts normally.

## Configuration
- MULT_EARLY_TERM_EN defined: in CALC, if the post-shift mplr is zero, exit to DONE on that edge regardless of count. Latency = max(1, position of highest set bit of B + 1) cycles; B=0 → 1 CALC cycle, P=0. Result identical to feature off.
- Not defined: CALC always runs exactly WIDTH cycles; latency fixed.

## Test plan
- Reset: assert rst_L=0 mid-stream → ready=1, done=0, P=0 immediately, without waiting for a clk edge.
- WIDTH=8, A=3, B=5, start one cycle → done high exactly 8 cycles after accepting edge, P=16'd15, ready=0 during CALC.
- A=8'hFF, B=8'hFF → P=16'hFE01; A=8'hFF, B=0 → P=0 (8 cycles, feature off).
- start held high throughout: A=7,B=9 then A=12,B=12 presented at DONE → done pulses 9 cycles apart, P=63 then P=144; start and operand changes during CALC ignored.
- Reset mid-CALC at cycle 4 of A=10,B=10 → no done, P=0; next start A=2,B=3 → P=6 after 8 cycles.
- MULT_EARLY_TERM_EN: B=8'h03, A=100 → done after 2 cycles, P=300; B=0 → done after 1 cycle, P=0; B=8'h80 → 8 cycles.
